// File: rtl/bsg_mem_2r1w_sync_ctrl_pkg.sv
// Shared types and helpers for the 2R1W synchronous-read memory controller.
package bsg_mem_2r1w_sync_ctrl_pkg;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eINIT  = 2'd1,
        eREADY = 2'd2
    } state_e;

    // Address width that stays at least one bit wide for single-entry arrays.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_mem_2r1w_sync_ctrl_rport.sv
// One read port: collision detect against the client write, macro read gating,
// and a registered select between the forwarded write data and the macro Q.
module bsg_mem_2r1w_sync_ctrl_rport #(
    parameter int width_p       = 32,
    parameter int addr_width_lp = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o,
    output logic                     mem_r_v_o,
    output logic [addr_width_lp-1:0] mem_r_addr_o,
    input  logic [width_p-1:0]       mem_r_data_i
);

    logic               r_v;
    logic               hit;
    logic               sel_r;
    logic [width_p-1:0] byp_r;

    assign r_v          = en_i & r_v_i;
    assign hit          = w_v_i & r_v & (w_addr_i == r_addr_i);
    assign mem_r_v_o    = r_v & ~hit;
    assign mem_r_addr_o = en_i ? r_addr_i : '0;

    // sel resets high so the output reads the zeroed bypass register, never
    // the unreset macro Q.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sel_r <= 1'b1;
            byp_r <= '0;
        end else if (r_v) begin
            sel_r <= hit;
            byp_r <= w_data_i;
        end
    end

    assign r_data_o = sel_r ? byp_r : mem_r_data_i;

endmodule

// File: rtl/bsg_mem_2r1w_sync_ctrl.sv
// Client-side controller for a 2R1W sync-read macro: init sweep after reset,
// then write passthrough with write-first forwarding on read collisions.
//
//   state  | meaning
//   eIDLE  | reset state, all outputs quiet
//   eINIT  | writing init_val_p to entry cnt, one entry per cycle
//   eREADY | in service until the next reset
module bsg_mem_2r1w_sync_ctrl
    import bsg_mem_2r1w_sync_ctrl_pkg::*;
#(
    parameter int                 width_p       = 32,
    parameter int                 els_p         = 32,
    parameter logic [width_p-1:0] init_val_p    = '0,
    parameter int                 addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     ready_o,

    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,

    input  logic                     r0_v_i,
    input  logic [addr_width_lp-1:0] r0_addr_i,
    output logic [width_p-1:0]       r0_data_o,

    input  logic                     r1_v_i,
    input  logic [addr_width_lp-1:0] r1_addr_i,
    output logic [width_p-1:0]       r1_data_o,

    output logic                     mem_w_v_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,

    output logic                     mem_r0_v_o,
    output logic [addr_width_lp-1:0] mem_r0_addr_o,
    input  logic [width_p-1:0]       mem_r0_data_i,

    output logic                     mem_r1_v_o,
    output logic [addr_width_lp-1:0] mem_r1_addr_o,
    input  logic [width_p-1:0]       mem_r1_data_i
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
    localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp + 1)'(els_p);

    state_e                   state_r;
    state_e                   state_n;
    logic [addr_width_lp-1:0] cnt_r;
    logic                     cnt_last;
    logic                     ready;
    logic                     w_v;

    assign cnt_last = (cnt_r == last_addr_lp);
    assign ready    = (state_r == eREADY);
    assign w_v      = w_v_i & ready;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            eIDLE:   state_n = eINIT;
            eINIT:   if (cnt_last) state_n = eREADY;
            eREADY:  state_n = eREADY;
            default: state_n = eIDLE;
        endcase
    end

    // Sweep counter holds at the last entry once the sweep is done.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r <= '0;
        end else if (state_r == eINIT && !cnt_last) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    always_comb begin
        ready_o      = 1'b0;
        mem_w_v_o    = 1'b0;
        mem_w_addr_o = '0;
        mem_w_data_o = '0;
        case (state_r)
            eINIT: begin
                mem_w_v_o    = 1'b1;
                mem_w_addr_o = cnt_r;
                mem_w_data_o = init_val_p;
            end
            eREADY: begin
                ready_o      = 1'b1;
                mem_w_v_o    = w_v_i;
                mem_w_addr_o = w_addr_i;
                mem_w_data_o = w_data_i;
            end
            default: ;
        endcase
    end

    bsg_mem_2r1w_sync_ctrl_rport #(
        .width_p       (width_p),
        .addr_width_lp (addr_width_lp)
    ) rport0 (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (ready),
        .w_v_i        (w_v),
        .w_addr_i     (w_addr_i),
        .w_data_i     (w_data_i),
        .r_v_i        (r0_v_i),
        .r_addr_i     (r0_addr_i),
        .r_data_o     (r0_data_o),
        .mem_r_v_o    (mem_r0_v_o),
        .mem_r_addr_o (mem_r0_addr_o),
        .mem_r_data_i (mem_r0_data_i)
    );

    bsg_mem_2r1w_sync_ctrl_rport #(
        .width_p       (width_p),
        .addr_width_lp (addr_width_lp)
    ) rport1 (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (ready),
        .w_v_i        (w_v),
        .w_addr_i     (w_addr_i),
        .w_data_i     (w_data_i),
        .r_v_i        (r1_v_i),
        .r_addr_i     (r1_addr_i),
        .r_data_o     (r1_data_o),
        .mem_r_v_o    (mem_r1_v_o),
        .mem_r_addr_o (mem_r1_addr_o),
        .mem_r_data_i (mem_r1_data_i)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (!ready_o) begin
                assert (!(w_v_i | r0_v_i | r1_v_i))
                    else $error("client request while controller not ready");
            end
            assert (!(w_v_i  && ({1'b0, w_addr_i}  >= els_lp))) else $error("write address out of range");
            assert (!(r0_v_i && ({1'b0, r0_addr_i} >= els_lp))) else $error("read 0 address out of range");
            assert (!(r1_v_i && ({1'b0, r1_addr_i} >= els_lp))) else $error("read 1 address out of range");
            assert (!(mem_w_v_o && mem_r0_v_o && (mem_w_addr_o == mem_r0_addr_o)))
                else $error("macro read 0 and write to the same address");
            assert (!(mem_w_v_o && mem_r1_v_o && (mem_w_addr_o == mem_r1_addr_o)))
                else $error("macro read 1 and write to the same address");
        end
    end
`endif

endmodule

// File: doc/bsg_mem_2r1w_sync_ctrl.md
Name: bsg_mem_2r1w_sync_ctrl

Overview:
- Client-side controller that drives a 2R1W synchronous-read memory macro (1-cycle read latency, no reset, simultaneous read/write to the same address forbidden).
- After reset, runs an init sweep that writes init_val_p to every entry, then raises ready_o.
- In service, resolves same-cycle read/write address collisions: it suppresses the colliding memory read and forwards the write data, giving write-first semantics to the client.
- Sits between a register-file user (e.g. a core's RF stage) and the hardened memory instance.

Parameters:
- width_p, 32, data width in bits.
- els_p, 32, number of entries; must be >= 2.
- init_val_p, 0, value written to every entry during the init sweep (width_p bits).
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived; not overridden).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- ready_o  out  1  high when the client may issue requests.
- w_v_i  in  1  client write valid.
- w_addr_i  in  addr_width_lp  client write address.
- w_data_i  in  width_p  client write data.
- r0_v_i  in  1  client read port 0 valid.
- r0_addr_i  in  addr_width_lp  read port 0 address.
- r0_data_o  out  width_p  read port 0 data, one cycle after r0_v_i.
- r1_v_i, r1_addr_i, r1_data_o: same as port 0, for read port 1.
- mem_w_v_o  out  1  memory write enable.
- mem_w_addr_o  out  addr_width_lp  memory write address.
- mem_w_data_o  out  width_p  memory write data.
- mem_r0_v_o  out  1  memory read port 0 enable.
- mem_r0_addr_o  out  addr_width_lp  memory read port 0 address.
- mem_r0_data_i  in  width_p  memory read port 0 data.
- mem_r1_v_o, mem_r1_addr_o, mem_r1_data_i: same as port 0, for memory read port 1.

Behaviour:
- Clock is clk_i; reset_i is asynchronous and active-high. All state registers reset asynchronously.
- FSM states:
  - eIDLE is the reset state. Exit to eINIT unconditionally on the first clock edge with reset_i low.
  - eINIT drives mem_w_v_o=1, mem_w_addr_o=cnt, mem_w_data_o=init_val_p. cnt increments each cycle. When cnt==els_p-1, go to eREADY. cnt does not wrap.
  - eREADY is terminal until reset.
- ready_o is high only in eREADY. It first rises els_p+1 cycles after reset deassertion (33 for els_p=32).
- Outputs while reset is asserted and in eIDLE:
  - ready_o, mem_w_v_o, mem_r0_v_o, mem_r1_v_o are 0.
  - All memory address and data outputs are 0.
  - r0_data_o and r1_data_o are 0.
- Client requests while ready_o=0:
  - They are ignored: no memory reads, no memory writes beyond the init sweep.
  - Simulation-only $error fires.
- In eREADY, writes pass straight through: mem_w_v_o=w_v_i, mem_w_addr_o=w_addr_i, mem_w_data_o=w_data_i. Writes are never delayed.
- Read port k in eREADY:
  - Collision is defined as hit_k = w_v_i & rk_v_i & (w_addr_i==rk_addr_i).
  - mem_rk_v_o = rk_v_i & ~hit_k; mem_rk_addr_o = rk_addr_i.
  - When rk_v_i=1, register sel_k<=hit_k and byp_k<=w_data_i on the clock edge.
  - rk_data_o = sel_k ? byp_k : mem_rk_data_i.
  - Read latency is exactly one cycle in both the bypass and memory cases.
- Hold: when rk_v_i=0, sel_k and byp_k are unchanged and mem_rk_v_o=0. The macro holds Q, so rk_data_o keeps its last value.
- Reset values: sel_k=1, byp_k=0. This forces rk_data_o=0 regardless of macro X.
- Both ports may bypass in the same cycle. The two ports are fully independent.
- Reset asserted mid-init or mid-service:
  - All outputs return to their reset values immediately.
  - The sweep restarts from address 0.
  - In-flight reads are discarded.
- Simulation-only assertions:
  - Address >= els_p on any valid request is an error.
  - mem_w_v_o together with mem_rk_v_o at an equal address must never occur.

Decomposition:
- Package bsg_mem_2r1w_sync_ctrl_pkg holds the FSM state enum {eIDLE, eINIT, eREADY}.
- Sub-module bsg_mem_2r1w_sync_ctrl_rport implements hit detection, the mem_v gating, sel/byp registers and the output mux. It is instantiated twice.
- Top level holds the FSM, the init counter, write passthrough/init muxing, ready_o gating and the assertions.

Test Plan:
- Reset, then deassert (els_p=32, init_val_p=0) -> mem writes addr 0..31 with data 0, one per cycle; ready_o rises on cycle 33; r*_data_o=0 throughout.
- Write addr 5 = 0xDEADBEEF; next cycle r0 reads addr 5 (memory model) -> mem_r0_v_o=1, r0_data_o=0xDEADBEEF one cycle later.
- Same cycle: write addr 7 = 0x12345678, r0 and r1 read addr 7 -> mem_w_v_o=1, mem_r0_v_o=mem_r1_v_o=0; next cycle both r*_data_o=0x12345678; memory holds 0x12345678 afterwards.
- Write addr 7 = 0xA5A5A5A5, r0 reads 7, r1 reads 3 (holds 0x33) -> r0_data_o=0xA5A5A5A5 from bypass, r1_data_o=0x33 from memory.
- r0 reads addr 3 = 0x33, then r0_v_i=0 for 3 cycles while writing addr 3 = 0x99 -> r0_data_o stays 0x33 all 3 cycles.
- Assert reset at init cycle 10 for 2 cycles -> outputs go to 0 immediately; after release the sweep restarts at addr 0; ready_o rises 33 cycles after release.
